// File: rtl/nfca_rx_median_demod.sv
// NFC-A receive ASK demodulator: sliding-window rank-order baseline with a shift-derived threshold.
// Optional hysteresis on the decision when NFCA_RX_HYST_EN is defined.
module nfca_rx_median_demod #(
  parameter int unsigned DW      = 12,
  parameter int unsigned N       = 21,
  parameter int unsigned RANK    = 12,
  parameter int unsigned RAW_TAP = 10,
  parameter int unsigned SA      = 7,
  parameter int unsigned SB      = 8,
  parameter int unsigned WARMUP  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_en,
  input  logic [DW-1:0] sample,
  output logic          rx_ask_en,
  output logic          rx_ask,
  output logic [DW-1:0] rx_lpf_data,
  output logic [DW-1:0] rx_raw_data,
  output logic          rx_overrun,
  output logic          busy
);

  localparam int unsigned PW = $clog2(N + 2);
  localparam logic [PW-1:0] LAST_PHASE = PW'(N + 1);
  localparam logic [7:0] WU = 8'(WARMUP);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [7:0]    wcnt;
  logic [DW-1:0] window   [N];
  logic [DW-1:0] sorted   [N];
  logic [DW-1:0] sort_nxt [N];
  logic [DW-1:0] lpf, raw, t_on;
  logic          ask_nxt;

  // One transposition phase: odd phases pair (0,1),(2,3)..., even phases pair (1,2),(3,4)...
  always_comb begin
    for (int unsigned i = 0; i < N; i++) sort_nxt[i] = sorted[i];
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (((i % 2) == 0) == phase[0]) begin
        if (sorted[i] > sorted[i+1]) begin
          sort_nxt[i]   = sorted[i+1];
          sort_nxt[i+1] = sorted[i];
        end
      end
    end
  end

  assign lpf  = sorted[RANK];
  assign raw  = window[RAW_TAP];
  assign t_on = lpf - (lpf >> SA) - (lpf >> SB);

`ifdef NFCA_RX_HYST_EN
  logic [DW-1:0] t_off;
  assign t_off   = lpf - (lpf >> SB);
  assign ask_nxt = rx_ask ? (raw < t_off) : (raw < t_on);
`else
  assign ask_nxt = (raw < t_on);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      wcnt        <= '0;
      rx_ask_en   <= 1'b0;
      rx_ask      <= 1'b0;
      rx_lpf_data <= '0;
      rx_raw_data <= '0;
      rx_overrun  <= 1'b0;
      busy        <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        window[i] <= '0;
        sorted[i] <= '0;
      end
    end else begin
      rx_ask_en  <= 1'b0;
      rx_overrun <= 1'b0;
      if (sample_en) begin
        window[0] <= sample;
        for (int unsigned i = 1; i < N; i++) window[i] <= window[i-1];
      end
      case (state)
        IDLE: begin
          busy <= sample_en;
          if (sample_en) state <= LOAD;
        end
        LOAD: begin
          busy <= 1'b1;
          if (sample_en) begin
            rx_overrun <= 1'b1;
            state      <= LOAD;
          end else begin
            sorted <= window;
            phase  <= PW'(1);
            state  <= SORT;
          end
        end
        SORT: begin
          if (sample_en) begin
            rx_overrun <= 1'b1;
            busy       <= 1'b1;
            state      <= LOAD;
          end else begin
            sorted <= sort_nxt;
            if (phase == LAST_PHASE) begin
              busy  <= 1'b0;
              state <= OUT;
            end else begin
              busy  <= 1'b1;
              phase <= phase + PW'(1);
            end
          end
        end
        OUT: begin
          // raw is read before this edge's shift, so a sample landing here still sees the sorted window
          if (wcnt < WU) begin
            wcnt <= wcnt + 8'd1;
          end else begin
            rx_ask_en   <= 1'b1;
            rx_ask      <= ask_nxt;
            rx_lpf_data <= lpf;
            rx_raw_data <= raw;
          end
          busy  <= sample_en;
          state <= sample_en ? LOAD : IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nfca_rx_median_demod.sv
// Scoreboard bench for nfca_rx_median_demod: a reference model predicts each strobe at drive time.
module tb_nfca_rx_median_demod;

  localparam int unsigned DW = 12, N = 21, RANK = 12, RAW_TAP = 10, SA = 7, SB = 8, WARMUP = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_en;
  logic [DW-1:0] sample;
  logic          rx_ask_en, rx_ask, rx_overrun, busy;
  logic [DW-1:0] rx_lpf_data, rx_raw_data;

  nfca_rx_median_demod #(
    .DW(DW), .N(N), .RANK(RANK), .RAW_TAP(RAW_TAP), .SA(SA), .SB(SB), .WARMUP(WARMUP)
  ) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .sample(sample),
    .rx_ask_en(rx_ask_en), .rx_ask(rx_ask), .rx_lpf_data(rx_lpf_data),
    .rx_raw_data(rx_raw_data), .rx_overrun(rx_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          ask;
    logic [DW-1:0] lpf;
    logic [DW-1:0] raw;
    int unsigned   cyc;
  } exp_t;

  exp_t q[$];

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned ovr_cnt = 0, exp_ovr = 0, strobe_cnt = 0, ones_cnt = 0;
  logic [DW-1:0] last_lpf, last_raw;

  logic [DW-1:0] mwin [N];
  int unsigned   msorts;
  bit            mprev;
  bit            last_short;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_lpf();
    logic [DW-1:0] a [N];
    logic [DW-1:0] t;
    int j;
    for (int i = 0; i < N; i++) a[i] = mwin[i];
    for (int i = 1; i < N; i++) begin
      t = a[i];
      j = i - 1;
      while (j >= 0 && a[j] > t) begin
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = t;
    end
    return a[RANK];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mwin[i] = '0;
    msorts     = 0;
    mprev      = 1'b0;
    last_short = 1'b0;
  endtask

  task automatic drive(input logic [DW-1:0] v, input int unsigned gap, input bit kill);
    exp_t e;
    int   l, ton, toff, r;
    bit   ask;
    if (last_short) exp_ovr++;
    for (int i = N - 1; i > 0; i--) mwin[i] = mwin[i-1];
    mwin[0]   = v;
    sample    = v;
    sample_en = 1'b1;
    e.cyc     = cyc + N + 4;
    @(negedge clk);
    sample_en  = 1'b0;
    last_short = (gap < N + 3);
    if (!kill && !last_short) begin
      if (msorts < WARMUP) msorts++;
      else begin
        l    = int'(model_lpf());
        r    = int'(mwin[RAW_TAP]);
        ton  = l - l / (2 ** SA) - l / (2 ** SB);
        toff = l - l / (2 ** SB);
`ifdef NFCA_RX_HYST_EN
        ask = mprev ? (r < toff) : (r < ton);
`else
        ask = (r < ton);
        if (toff < 0) ask = 1'b0;
`endif
        e.ask = ask;
        e.lpf = DW'(l);
        e.raw = DW'(r);
        q.push_back(e);
        mprev = ask;
      end
    end
    for (int k = 1; k < gap; k++) begin
      @(negedge clk);
      if (k == 4) check("busy_sorting", busy, 1);
      if (k == N + 3 && gap > N + 3 && !kill) check("busy_done", busy, 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_overrun) ovr_cnt++;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("missed_strobe", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (rx_ask_en) begin
        exp_t e;
        strobe_cnt++;
        if (rx_ask) ones_cnt++;
        last_lpf = rx_lpf_data;
        last_raw = rx_raw_data;
        check("strobe_vs_overrun", rx_overrun, 0);
        if (q.size() == 0) check("spurious_strobe", q.size(), 1);
        else begin
          e = q.pop_front();
          check("latency", cyc, e.cyc);
          check("rx_ask", rx_ask, e.ask);
          check("rx_lpf_data", rx_lpf_data, e.lpf);
          check("rx_raw_data", rx_raw_data, e.raw);
        end
      end
    end
  end

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_ask_en"}, rx_ask_en, 0);
    check({pfx, "_ask"}, rx_ask, 0);
    check({pfx, "_lpf"}, rx_lpf_data, 0);
    check({pfx, "_raw"}, rx_raw_data, 0);
    check({pfx, "_overrun"}, rx_overrun, 0);
    check({pfx, "_busy"}, busy, 0);
  endtask

  int unsigned s0, o0, a0;

  initial begin
    rst = 1'b1; sample_en = 1'b0; sample = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Warm-up: 32 discarded sorts, then output from the 33rd
    for (int i = 0; i < WARMUP; i++) drive(12'd2000, 32, 1'b0);
    check("warmup_silent", strobe_cnt, 0);
    drive(12'd2000, 32, 1'b0);
    check("warmup_first", strobe_cnt, 1);
    for (int i = 0; i < 7; i++) drive(12'd2000, 32, 1'b0);

    // Single dips: 1960 detected once, 1978 (equal) and 1985 not
    a0 = ones_cnt;
    drive(12'd1960, 32, 1'b0);
    for (int i = 0; i < 24; i++) drive(12'd2000, 32, 1'b0);
    check("dip_1960_ones", ones_cnt - a0, 1);
    a0 = ones_cnt;
    drive(12'd1978, 32, 1'b0);
    for (int i = 0; i < 24; i++) drive(12'd2000, 32, 1'b0);
    drive(12'd1985, 32, 1'b0);
    for (int i = 0; i < 24; i++) drive(12'd2000, 32, 1'b0);
    check("dip_edge_ones", ones_cnt - a0, 0);

    // Hysteresis pair
    a0 = ones_cnt;
    drive(12'd1960, 32, 1'b0);
    drive(12'd1990, 32, 1'b0);
    for (int i = 0; i < 24; i++) drive(12'd2000, 32, 1'b0);
`ifdef NFCA_RX_HYST_EN
    check("hyst_ones", ones_cnt - a0, 2);
`else
    check("hyst_ones", ones_cnt - a0, 1);
`endif

    // Overrun: samples every 10 clocks
    o0 = ovr_cnt; s0 = strobe_cnt;
    for (int i = 0; i < 5; i++) drive(12'd2000, 10, 1'b0);
    drive(12'd2000, 32, 1'b0);
    check("overrun_count", ovr_cnt - o0, 5);
    check("overrun_strobes", strobe_cnt - s0, 1);
    // Minimum spacing: no overrun, every sample emitted
    o0 = ovr_cnt; s0 = strobe_cnt;
    for (int i = 0; i < 10; i++) drive(12'd2000, N + 3, 1'b0);
    drive(12'd2000, 32, 1'b0);
    check("min_gap_overruns", ovr_cnt - o0, 0);
    check("min_gap_strobes", strobe_cnt - s0, 11);
    check("overrun_model", ovr_cnt, exp_ovr);

    // Reset at sort phase 5
    drive(12'd2000, 6, 1'b1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midsort");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    s0 = strobe_cnt;
    for (int i = 0; i < WARMUP; i++) drive(12'd100, 32, 1'b0);
    check("rst_warmup_silent", strobe_cnt - s0, 0);
    drive(12'd100, 32, 1'b0);
    check("rst_warmup_first", strobe_cnt - s0, 1);

    // Rank/tap: permutation of 0..20
    for (int i = 0; i < N; i++) drive(DW'((i * 8) % N), 32, 1'b0);
    check("rank_lpf", last_lpf, 12);
    check("tap_raw", last_raw, 17);

    repeat (40) @(negedge clk);
    check("queue_drained", q.size(), 0);
    check("overrun_total", ovr_cnt, exp_ovr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
